// File: rtl/fir_hls_pkg.sv
// Shared types and default widths for the FIR product accumulator.
// The guard bit lets the rounding offset be added without overflowing the accumulator.
package fir_hls_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_PROD_W  = 25;
    localparam int DEF_ACC_W   = 32;
    localparam int DEF_OUT_W   = 16;
    localparam int DEF_NTAPS   = 32;
    localparam int DEF_SHIFT   = 9;
    localparam int RND_GUARD_W = 1;

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up arithmetic right shift of the accumulator, then clamp to the signed
// output range; o_sat reports when the clamp changed the value.
module fir_round_sat
    import fir_hls_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic [ACC_W-1:0] i_acc,
    output logic [OUT_W-1:0] o_data,
    output logic             o_sat
);

    localparam int SUM_W = ACC_W + RND_GUARD_W;
    localparam logic signed [SUM_W-1:0] HALF  = SUM_W'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;

    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_shr;

    assign w_sum = SUM_W'($signed(i_acc)) + HALF;
    assign w_shr = w_sum >>> SHIFT;

    always_comb begin
        o_sat  = 1'b0;
        o_data = w_shr[OUT_W-1:0];
        if (w_shr > MAX_V) begin
            o_data = MAX_V[OUT_W-1:0];
            o_sat  = 1'b1;
        end else if (w_shr < MIN_V) begin
            o_data = MIN_V[OUT_W-1:0];
            o_sat  = 1'b1;
        end
    end

endmodule

// File: rtl/fir_prod_accum.sv
// Sums a frame of signed tap products, then rounds/saturates one output sample and
// holds it until the downstream handshake completes.
module fir_prod_accum
    import fir_hls_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int NTAPS  = DEF_NTAPS,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    input  logic              prod_last,
    output logic              prod_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sat_flag,
    output logic              tap_err
);

    localparam int CNT_W = $clog2(NTAPS) + 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NTAPS - 1);

    state_t             r_state, w_state_nxt;
    logic [ACC_W-1:0]   r_acc, w_acc_nxt;
    logic [CNT_W-1:0]   r_tap_cnt, w_tap_cnt_nxt;
    logic [OUT_W-1:0]   r_out_data, w_out_data_nxt;
    logic               r_out_valid, w_out_valid_nxt;
    logic               r_sat, w_sat_nxt;
    logic               r_tap_err, w_tap_err_nxt;

    logic               w_accept;
    logic               w_cnt_last;
    logic               w_beat_last;
    logic [ACC_W-1:0]   w_prod_sext;
    logic [OUT_W-1:0]   w_rs_data;
    logic               w_rs_sat;

    assign prod_ready  = (r_state == ACCUM);
    assign w_accept    = prod_valid & prod_ready;
    assign w_cnt_last  = (r_tap_cnt == LAST_TAP);
    assign w_beat_last = prod_last | w_cnt_last;
    assign w_prod_sext = ACC_W'($signed(prod_in));

    fir_round_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .i_acc  (r_acc),
        .o_data (w_rs_data),
        .o_sat  (w_rs_sat)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_tap_cnt_nxt   = r_tap_cnt;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_sat_nxt       = r_sat;
        w_tap_err_nxt   = r_tap_err;
        unique case (r_state)
            ACCUM: begin
                if (w_accept) begin
                    w_acc_nxt = (r_tap_cnt == '0) ? w_prod_sext : r_acc + w_prod_sext;
                    if (w_beat_last) begin
                        w_tap_cnt_nxt = '0;
                        w_state_nxt   = ROUND;
                        // Early prod_last or a missing one at the final tap is a framing error
                        if (prod_last != w_cnt_last) begin
                            w_tap_err_nxt = 1'b1;
                        end
                    end else begin
                        w_tap_cnt_nxt = r_tap_cnt + CNT_W'(1);
                    end
                end
            end
            ROUND: begin
                w_out_data_nxt  = w_rs_data;
                w_out_valid_nxt = 1'b1;
                w_sat_nxt       = r_sat | w_rs_sat;
                w_state_nxt     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_tap_cnt   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_tap_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_tap_cnt   <= w_tap_cnt_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_sat       <= w_sat_nxt;
            r_tap_err   <= w_tap_err_nxt;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign sat_flag  = r_sat;
    assign tap_err   = r_tap_err;

endmodule

// File: tb/tb_fir_prod_accum.sv
// Scoreboard bench: frames of products are driven, the expected sample is computed from
// plain arithmetic on the frame and queued, and a monitor checks every presented output.
module tb_fir_prod_accum;

    localparam int PROD_W = 25;
    localparam int OUT_W  = 16;
    localparam int NTAPS  = 32;
    localparam int SHIFT  = 9;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic [PROD_W-1:0] prod_in;
    logic              prod_valid;
    logic              prod_last;
    logic              prod_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              sat_flag;
    logic              tap_err;

    typedef struct {
        logic signed [OUT_W-1:0] data;
        logic                    sat;
        logic                    err;
    } exp_t;

    exp_t exp_q[$];
    int   beats[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_acc_cyc = -100;
    bit   stall_req = 1'b0;
    bit   rand_ready = 1'b0;
    bit   model_sat = 1'b0;
    bit   model_err = 1'b0;

    fir_prod_accum dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_last  (prod_last),
        .prod_ready (prod_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sat_flag   (sat_flag),
        .tap_err    (tap_err)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Reference: floor((sum + 2^(SHIFT-1)) / 2^SHIFT), clamped; flags are sticky since reset.
    task automatic push_expected(input longint sum, input bit err);
        longint r;
        exp_t   e;
        bit     sat;
        r   = (sum + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
        sat = 1'b0;
        if (r > 32767) begin
            r   = 32767;
            sat = 1'b1;
        end else if (r < -32768) begin
            r   = -32768;
            sat = 1'b1;
        end
        model_sat = model_sat | sat;
        model_err = model_err | err;
        e.data = OUT_W'(r);
        e.sat  = model_sat;
        e.err  = model_err;
        exp_q.push_back(e);
    endtask

    task automatic send_beat(input int val, input bit last, output bit ok);
        int guard;
        guard = 0;
        @(negedge ap_clk);
        prod_in    = PROD_W'(val);
        prod_valid = 1'b1;
        prod_last  = last;
        while (!prod_ready && guard < 500) begin
            @(negedge ap_clk);
            guard++;
        end
        ok = prod_ready;
        if (!prod_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout: prod_ready got 0, required 1 within 500 cycles");
        end else begin
            @(posedge ap_clk);
            #1;
        end
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    // A frame ends on prod_last or on the NTAPS-th beat; any other ending is a framing error.
    task automatic send_frame(input bit give_last, input bit gaps);
        longint sum;
        int     n;
        bit     ok;
        sum = 0;
        n   = beats.size();
        foreach (beats[i]) sum += beats[i];
        push_expected(sum, give_last ? (n != NTAPS) : 1'b1);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge ap_clk);
            send_beat(beats[i], give_last && (i == n - 1), ok);
            if (!ok) break;
        end
        last_acc_cyc = cyc;
        beats.delete();
    endtask

    task automatic fill(input int val, input int n);
        for (int i = 0; i < n; i++) beats.push_back(val);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 3000) begin
            @(negedge ap_clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d samples pending, required 0", exp_q.size());
        end
    endtask

    // Downstream: optional 5-cycle stall on each new output, otherwise ready or random.
    initial begin
        int stall_left;
        bit seen;
        stall_left = 0;
        seen       = 1'b0;
        out_ready  = 1'b1;
        forever begin
            @(posedge ap_clk);
            #1;
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (out_valid && !seen && stall_req) begin
                out_ready  = 1'b0;
                stall_left = 4;
            end else begin
                out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            seen = out_valid;
        end
    end

    // Monitor: every cycle an output is presented it must match the queue head.
    initial begin
        bit prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (ap_rst) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid) begin
                    if (!prev_valid) check("out_valid_latency", cyc, last_acc_cyc + 1);
                    check("prod_ready_in_hold", prod_ready, 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got data %0d, required no output",
                                 $signed(out_data));
                    end else begin
                        check("out_data", $signed(out_data), exp_q[0].data);
                        check("sat_flag", sat_flag, exp_q[0].sat);
                        check("tap_err", tap_err, exp_q[0].err);
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
                prev_valid = out_valid;
            end
        end
    end

    initial begin
        int v;
        int n;
        int kind;
        bit ok;
        int rnd_sums[4];
        int rnd_exp[4];

        ap_rst     = 1'b1;
        prod_in    = '0;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        repeat (3) @(negedge ap_clk);
        check("reset_out_data", out_data, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_sat_flag", sat_flag, 0);
        check("reset_tap_err", tap_err, 0);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check("ready_after_reset", prod_ready, 1);

        // 32 x 512 -> 32
        fill(512, NTAPS);
        send_frame(1'b1, 1'b0);
        wait_drain();

        // Saturation in both directions
        fill(16744449, NTAPS);
        send_frame(1'b1, 1'b0);
        fill(-16744448, NTAPS);
        send_frame(1'b1, 1'b0);
        wait_drain();

        // Rounding boundaries, cross-checked against hand-computed results
        rnd_sums = '{256, 255, -256, -257};
        rnd_exp  = '{1, 0, 0, -1};
        for (int k = 0; k < 4; k++) begin
            beats.push_back(rnd_sums[k]);
            fill(0, NTAPS - 1);
            send_frame(1'b1, 1'b0);
            wait_drain();
            check("round_direct", $signed(out_data), rnd_exp[k]);
        end

        // Early prod_last at beat 10, then a correct full frame
        fill(1000, 10);
        send_frame(1'b1, 1'b0);
        fill(-700, NTAPS);
        send_frame(1'b1, 1'b0);
        // Full frame missing prod_last
        fill(333, NTAPS);
        send_frame(1'b0, 1'b0);
        wait_drain();

        // Downstream stall of 5 cycles, back-to-back frames queued behind it
        stall_req = 1'b1;
        fill(1234, NTAPS);
        send_frame(1'b1, 1'b0);
        fill(-4321, NTAPS);
        send_frame(1'b1, 1'b0);
        wait_drain();
        stall_req = 1'b0;

        // Randomized frames with gaps and random backpressure
        rand_ready = 1'b1;
        for (int f = 0; f < 24; f++) begin
            kind = $urandom_range(0, 9);
            n    = (kind < 2) ? $urandom_range(1, NTAPS - 1) : NTAPS;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) v = int'($urandom_range(0, 33554431)) - 16777216;
                else v = int'($urandom_range(0, 80000)) - 40000;
                beats.push_back(v);
            end
            send_frame(kind != 2, 1'b1);
        end
        wait_drain();
        rand_ready = 1'b0;

        // Reset pulse after 17 beats of a sample
        for (int i = 0; i < 17; i++) send_beat(5000, 1'b0, ok);
        @(negedge ap_clk);
        ap_rst = 1'b1;
        #2;
        check("midreset_out_data", out_data, 0);
        check("midreset_out_valid", out_valid, 0);
        check("midreset_sat_flag", sat_flag, 0);
        check("midreset_tap_err", tap_err, 0);
        @(negedge ap_clk);
        ap_rst    = 1'b0;
        model_sat = 1'b0;
        model_err = 1'b0;
        @(negedge ap_clk);
        check("ready_after_midreset", prod_ready, 1);
        fill(512, NTAPS);
        send_frame(1'b1, 1'b0);
        wait_drain();
        check("post_reset_direct", $signed(out_data), 32);

        repeat (3) @(negedge ap_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
